// File: rtl/clk_div_n.sv
// clk_div_n: multi-channel programmable clock divider.
// Each channel produces clk_o with phases of D+1 clk_i cycles and period
// 2*(D+1), where D is sampled from div_i only at period starts. Disabling a
// channel never truncates a high phase.
// Optional feature: define CLK_DIV_ALIGN_EN to add align_i, which restarts
// every running channel in phase on the next edge.
module clk_div_n #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
`ifdef CLK_DIV_ALIGN_EN
  input  logic                    align_i,
`endif
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH*CNT_W-1:0] div_i,
  output logic [NUM_CH-1:0]       clk_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] shadow_reg, shadow_next;
    logic             clk_reg, clk_next;
    logic             tick_reg, tick_next;
    logic             busy_w;
    logic [CNT_W-1:0] div_w;
    logic             term_w;

    assign div_w  = div_i[gi*CNT_W +: CNT_W];
    // Terminal count of the current phase, judged against the latched divide value.
    assign term_w = (cnt_reg == shadow_reg);

    // State register: all channel state, cleared asynchronously by reset_i.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        state_reg  <= ST_IDLE;
        cnt_reg    <= '0;
        shadow_reg <= '0;
        clk_reg    <= 1'b0;
        tick_reg   <= 1'b0;
      end else begin
        state_reg  <= state_next;
        cnt_reg    <= cnt_next;
        shadow_reg <= shadow_next;
        clk_reg    <= clk_next;
        tick_reg   <= tick_next;
      end
    end

    // Next-state logic: phase counting, toggling and graceful stop.
    always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      shadow_next = shadow_reg;
      clk_next    = clk_reg;
      tick_next   = 1'b0;
      case (state_reg)
        ST_IDLE: begin
          cnt_next = '0;
          clk_next = 1'b0;
          if (en_i[gi]) begin
            state_next  = ST_RUN;
            clk_next    = 1'b1;
            tick_next   = 1'b1;
            shadow_next = div_w;
          end
        end
        ST_RUN: begin
`ifdef CLK_DIV_ALIGN_EN
          // Align wins over terminal count and over a disable request.
          if (align_i) begin
            cnt_next    = '0;
            clk_next    = 1'b1;
            tick_next   = 1'b1;
            shadow_next = div_w;
          end else
`endif
          if (!en_i[gi] && !clk_reg) begin
            // Low phase is already "off": stop immediately.
            state_next = ST_IDLE;
            cnt_next   = '0;
            clk_next   = 1'b0;
          end else if (term_w) begin
            cnt_next = '0;
            clk_next = ~clk_reg;
            if (!en_i[gi]) begin
              // High phase finished on the same edge the disable was seen.
              state_next = ST_IDLE;
            end else if (!clk_reg) begin
              // Rising edge starts a new period: pulse and pick up new D.
              tick_next   = 1'b1;
              shadow_next = div_w;
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (!en_i[gi]) begin
              state_next = ST_STOP;
            end
          end
        end
        ST_STOP: begin
          // clk_reg is always high here; finish the high phase untouched.
          if (term_w) begin
            cnt_next   = '0;
            clk_next   = 1'b0;
            state_next = en_i[gi] ? ST_RUN : ST_IDLE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (en_i[gi]) begin
              state_next = ST_RUN;
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          clk_next   = 1'b0;
        end
      endcase
    end

    // Output logic: busy is any non-idle state; clk/tick come straight from flops.
    always_comb begin
      busy_w = (state_reg != ST_IDLE);
    end

    assign clk_o[gi]  = clk_reg;
    assign tick_o[gi] = tick_reg;
    assign busy_o[gi] = busy_w;
  end

endmodule

// File: tb/tb_clk_div_n.sv
// tb_clk_div_n: directed test of clk_div_n with a tick/high-phase scoreboard.
// Stimulus pushes the expected tick spacing and high-phase length per channel;
// a negedge monitor measures them and pops expectations as they occur.
// Define CLK_DIV_ALIGN_EN to also exercise align_i.
module tb_clk_div_n;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 16;

  logic                    clk_i;
  logic                    reset_i;
  logic [NUM_CH-1:0]       en_i;
  logic [NUM_CH*CNT_W-1:0] div_i;
  logic [NUM_CH-1:0]       clk_o;
  logic [NUM_CH-1:0]       tick_o;
  logic [NUM_CH-1:0]       busy_o;
`ifdef CLK_DIV_ALIGN_EN
  logic                    align_i;
`endif

  clk_div_n #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
`ifdef CLK_DIV_ALIGN_EN
    .align_i (align_i),
`endif
    .en_i    (en_i),
    .div_i   (div_i),
    .clk_o   (clk_o),
    .tick_o  (tick_o),
    .busy_o  (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int gap_q[NUM_CH][$];
  int hi_q[NUM_CH][$];
  int last_t[NUM_CH] = '{-1, -1};
  int hi_run[NUM_CH] = '{0, 0};
  int cyc = 0;
  int gap_meas;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: measure tick spacing and high-phase lengths, compare with the queues.
  always @(negedge clk_i) begin
    cyc++;
    for (int c = 0; c < NUM_CH; c++) begin
      if (tick_o[c] && !reset_i) begin
        gap_meas  = (last_t[c] < 0) ? 0 : cyc - last_t[c];
        last_t[c] = cyc;
        $display("t=%0t ch%0d tick gap=%0d", $time, c, gap_meas);
        if (gap_q[c].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tick_gap ch%0d: got unexpected tick (gap %0d), expected none", c, gap_meas);
        end else begin
          chk($sformatf("tick_gap ch%0d", c), gap_meas, gap_q[c].pop_front());
        end
      end else if (!busy_o[c] || reset_i) begin
        last_t[c] = -1;
      end
      if (clk_o[c] && !reset_i) begin
        hi_run[c]++;
      end else begin
        if (hi_run[c] > 0 && !reset_i) begin
          $display("t=%0t ch%0d high phase=%0d", $time, c, hi_run[c]);
          if (hi_q[c].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL high_len ch%0d: got unexpected high phase %0d, expected none", c, hi_run[c]);
          end else begin
            chk($sformatf("high_len ch%0d", c), hi_run[c], hi_q[c].pop_front());
          end
        end
        hi_run[c] = 0;
      end
    end
  end

  task automatic clocks(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic set_div(input int d0, input int d1);
    div_i = {CNT_W'(d1), CNT_W'(d0)};
  endtask

  initial begin
    reset_i = 1'b1;
    en_i    = '0;
    div_i   = '0;
`ifdef CLK_DIV_ALIGN_EN
    align_i = 1'b0;
`endif
    clocks(2);
    chk("reset clk_o", int'(clk_o), 0);
    chk("reset tick_o", int'(tick_o), 0);
    chk("reset busy_o", int'(busy_o), 0);
    reset_i = 1'b0;
    clocks(1);

    // Divide-by-2 on ch0.
    set_div(0, 0);
    gap_q[0].push_back(0);
    repeat (3) gap_q[0].push_back(2);
    repeat (4) hi_q[0].push_back(1);
    en_i = 2'b01;
    clocks(8);
    en_i = 2'b00;
    clocks(1);
    chk("d0 stop busy ch0", int'(busy_o[0]), 0);
    clocks(2);

    // Two channels, D=3 and D=1.
    set_div(3, 1);
    gap_q[0].push_back(0); gap_q[0].push_back(8);
    repeat (2) hi_q[0].push_back(4);
    gap_q[1].push_back(0);
    repeat (3) gap_q[1].push_back(4);
    repeat (4) hi_q[1].push_back(2);
    en_i = 2'b11;
    clocks(16);
    en_i = 2'b00;
    clocks(3);

    // Divide value changed mid-period takes effect at the next period.
    set_div(3, 0);
    gap_q[0].push_back(0); gap_q[0].push_back(8);
    gap_q[0].push_back(4); gap_q[0].push_back(4);
    hi_q[0].push_back(4);
    repeat (3) hi_q[0].push_back(2);
    en_i = 2'b01;
    clocks(2);
    set_div(1, 0);
    clocks(18);
    en_i = 2'b00;
    clocks(3);

    // Disable in the first high cycle: high phase still completes.
    set_div(3, 0);
    gap_q[0].push_back(0);
    hi_q[0].push_back(4);
    en_i = 2'b01;
    clocks(1);
    en_i = 2'b00;
    clocks(3);
    chk("stop hold clk ch0", int'(clk_o[0]), 1);
    chk("stop hold busy ch0", int'(busy_o[0]), 1);
    clocks(1);
    chk("stop end clk ch0", int'(clk_o[0]), 0);
    chk("stop end busy ch0", int'(busy_o[0]), 0);
    clocks(2);

    // Re-enable while stopping: phase continues without restart.
    gap_q[0].push_back(0); gap_q[0].push_back(8);
    repeat (2) hi_q[0].push_back(4);
    en_i = 2'b01;
    clocks(1);
    en_i = 2'b00;
    clocks(1);
    chk("stop state busy ch0", int'(busy_o[0]), 1);
    en_i = 2'b01;
    clocks(8);
    en_i = 2'b00;
    clocks(3);
    chk("resume end busy ch0", int'(busy_o[0]), 0);
    clocks(1);

    // Asynchronous reset mid-high, then restart on the first enabled edge.
    set_div(5, 0);
    gap_q[0].push_back(0);
    en_i = 2'b01;
    clocks(3);
    chk("pre-reset clk ch0", int'(clk_o[0]), 1);
    chk("pre-reset busy ch0", int'(busy_o[0]), 1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("async reset clk_o", int'(clk_o), 0);
    chk("async reset tick_o", int'(tick_o), 0);
    chk("async reset busy_o", int'(busy_o), 0);
    set_div(0, 0);
    clocks(1);
    gap_q[0].push_back(0);
    hi_q[0].push_back(1);
    reset_i = 1'b0;
    clocks(1);
    chk("post-reset tick ch0", int'(tick_o[0]), 1);
    en_i = 2'b00;
    clocks(3);

`ifdef CLK_DIV_ALIGN_EN
    // Align two channels with different divide values.
    set_div(1, 2);
    gap_q[0].push_back(0); gap_q[0].push_back(3); gap_q[0].push_back(4);
    repeat (3) hi_q[0].push_back(2);
    gap_q[1].push_back(0); gap_q[1].push_back(3);
    hi_q[1].push_back(6);
    en_i = 2'b11;
    clocks(3);
    align_i = 1'b1;
    clocks(1);
    align_i = 1'b0;
    chk("align clk_o", int'(clk_o), 3);
    chk("align tick_o", int'(tick_o), 3);
    clocks(4);
    en_i = 2'b00;
    clocks(4);
`endif

    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("gap_q left ch%0d", c), gap_q[c].size(), 0);
      chk($sformatf("hi_q left ch%0d", c), hi_q[c].size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_div_n.md
CLK_DIV_N -- requirements
Module: clk_div_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent divider channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 16, width of each divide value and phase counter.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port en_i  input  NUM_CH  per-channel run request.
REQ-006 SHALL have port div_i  input  NUM_CH*CNT_W  per-channel divide value D; channel c uses bits [c*CNT_W +: CNT_W].
REQ-007 SHALL have port clk_o  output  NUM_CH  per-channel divided clock, registered.
REQ-008 SHALL have port tick_o  output  NUM_CH  per-channel one-cycle pulse coincident with each clk_o rising edge, registered.
REQ-009 SHALL have port busy_o  output  NUM_CH  per-channel indication that the state is not IDLE.

Function
REQ-010 Each channel SHALL hold its own state (IDLE, RUN, STOP), a CNT_W phase counter, a CNT_W shadow divide register and a clk_o flop.
REQ-011 In RUN, each clk_o phase SHALL last D+1 clk_i cycles, giving period 2*(D+1); D=0 SHALL give divide-by-2.
REQ-012 On count==shadow, the channel SHALL toggle clk_o and clear the counter; otherwise the counter SHALL increment by 1.
REQ-013 In IDLE with en_i=1, the next edge SHALL enter RUN, set clk_o=1, pulse tick_o, clear the counter and load shadow from div_i.
REQ-014 On every clk_o 0->1 toggle in RUN, the channel SHALL pulse tick_o and reload shadow from div_i; div_i changes SHALL take effect only at period boundaries.
REQ-015 In RUN with en_i=0 and clk_o=0, the channel SHALL enter IDLE next edge with clk_o held 0 and the counter cleared.
REQ-016 In RUN with en_i=0 and clk_o=1, the channel SHALL enter STOP and complete the full high phase; at terminal count it SHALL drive clk_o=0 and enter IDLE.
REQ-017 In STOP with en_i=1, the channel SHALL return to RUN without truncating or restarting the current phase.
REQ-018 In IDLE, clk_o and tick_o SHALL be 0 and the counter SHALL be frozen at 0.
REQ-019 No clk_o high or low phase SHALL be shorter than D+1 cycles of the shadow value in force, except through reset_i or the align feature.
REQ-020 Channels SHALL be fully independent.

Reset
REQ-021 While reset_i=1, all channels SHALL asynchronously take state IDLE, counter 0, shadow 0, clk_o 0, tick_o 0 and busy_o 0, including when asserted mid-phase.
REQ-022 After reset_i deasserts, the first RUN entry SHALL occur on the first edge that samples en_i=1.

Configuration
REQ-023 With macro CLK_DIV_ALIGN_EN defined, the module SHALL add port align_i (input, 1 bit).
REQ-024 With CLK_DIV_ALIGN_EN defined, align_i=1 SHALL restart every channel in RUN on the next edge: counter 0, clk_o 1, tick_o pulse, shadow reloaded.
REQ-025 With CLK_DIV_ALIGN_EN defined, align SHALL take priority over a simultaneous terminal count, and channels in IDLE or STOP SHALL ignore align_i.
REQ-026 Without CLK_DIV_ALIGN_EN, the align_i port and its logic SHALL be absent and behaviour SHALL be as in REQ-010 to REQ-022.

Verification
REQ-027 Ch0 D=0, en_i=1 after reset: clk_o[0] SHALL toggle every cycle (period 2) and tick_o[0] SHALL pulse every 2nd cycle.
REQ-028 Ch0 D=3, ch1 D=1, both enabled: ch0 SHALL show high 4 / low 4 with tick every 8 cycles, and ch1 SHALL show high 2 / low 2 with tick every 4.
REQ-029 Ch0 D=3, div_i changed to 1 in the 2nd high cycle: the current period SHALL finish at 8 cycles and the next periods SHALL be 4.
REQ-030 Ch0 D=3, en_i dropped in the 1st high cycle: clk_o SHALL stay high 4 cycles total, then go 0 with busy_o falling on the same edge.
REQ-031 Ch0 D=5 running, reset_i asserted mid-high: clk_o, tick_o and busy_o SHALL go 0 without waiting for a clock edge.
REQ-032 CLK_DIV_ALIGN_EN, ch0 D=1, ch1 D=2, align_i pulsed: both clk_o SHALL rise together with simultaneous tick_o on the next edge.
